// File: rtl/fp_add_arbiter.sv
// Round-robin front end for a shared combinational half-precision add/sub datapath.
// Each accepted operation holds the datapath inputs for ADD_LAT cycles, then answers with its requester id.
module fp_add_arbiter #(
    parameter int unsigned ADD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req0_op,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic        req1_op,

    output logic [15:0] fpu_a,
    output logic [15:0] fpu_b,
    output logic        fpu_op,
    input  logic        fpu_sign,
    input  logic [4:0]  fpu_exp,
    input  logic [9:0]  fpu_mant,
    input  logic        fpu_ovf,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic        rsp_ovf,

    output logic        busy,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam logic [3:0] CntInit = 4'(ADD_LAT - 1);

    state_e      state_q;
    logic        last_grant_q;
    logic [3:0]  cnt_q;
    logic [15:0] fpu_a_q;
    logic [15:0] fpu_b_q;
    logic        fpu_op_q;
    logic        rsp_valid_q;
    logic        rsp_id_q;
    logic [15:0] rsp_result_q;
    logic        rsp_ovf_q;
    logic [15:0] op_count_q;

    logic grant0;
    logic grant1;
    logic accept;

    // On contention the requester that did not win last time gets the slot.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant_q;
            grant1 = !last_grant_q;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = (state_q == StIdle) && grant0;
    assign req1_ready = (state_q == StIdle) && grant1;
    assign accept     = req0_ready || req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            fpu_a_q      <= 16'd0;
            fpu_b_q      <= 16'd0;
            fpu_op_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 16'd0;
            rsp_ovf_q    <= 1'b0;
            op_count_q   <= 16'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        fpu_a_q      <= grant1 ? req1_a  : req0_a;
                        fpu_b_q      <= grant1 ? req1_b  : req0_b;
                        fpu_op_q     <= grant1 ? req1_op : req0_op;
                        rsp_id_q     <= grant1;
                        last_grant_q <= grant1;
                        cnt_q        <= CntInit;
                        state_q      <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        rsp_result_q <= {fpu_sign, fpu_exp, fpu_mant};
                        rsp_ovf_q    <= fpu_ovf;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 16'd1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign fpu_a      = fpu_a_q;
    assign fpu_b      = fpu_b_q;
    assign fpu_op     = fpu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign op_count   = op_count_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: one instance at ADD_LAT=1, one at ADD_LAT=3,
// each fed by a small lookup-table model of the FP datapath.
module tb_fp_add_arbiter;

    logic clk;
    logic rst_n;

    logic        req0_valid, req0_ready, req0_op;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_op;
    logic [15:0] req1_a, req1_b;
    logic [15:0] fpu_a, fpu_b;
    logic        fpu_op, fpu_sign, fpu_ovf;
    logic [4:0]  fpu_exp;
    logic [9:0]  fpu_mant;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf, busy;
    logic [15:0] rsp_result, op_count;

    logic        req0_valid3, req0_ready3, req0_op3;
    logic [15:0] req0_a3, req0_b3;
    logic        req1_valid3, req1_ready3, req1_op3;
    logic [15:0] req1_a3, req1_b3;
    logic [15:0] fpu_a3, fpu_b3;
    logic        fpu_op3, fpu_sign3, fpu_ovf3;
    logic [4:0]  fpu_exp3;
    logic [9:0]  fpu_mant3;
    logic        rsp_valid3, rsp_ready3, rsp_id3, rsp_ovf3, busy3;
    logic [15:0] rsp_result3, op_count3;

    int tests;
    int fails;

    // op=1 is addition. Returns {ovf, result}.
    function automatic logic [16:0] fp_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic op);
        case ({a, b, op})
            {16'h3C00, 16'h3C00, 1'b1}: return 17'h04000;
            {16'h4000, 16'h3C00, 1'b1}: return 17'h04200;
            {16'h4200, 16'h3C00, 1'b0}: return 17'h04000;
            {16'h7BFF, 16'h7BFF, 1'b1}: return 17'h17C00;
            default:                    return {1'b0, a ^ b};
        endcase
    endfunction

    assign {fpu_ovf, fpu_sign, fpu_exp, fpu_mant}     = fp_model(fpu_a, fpu_b, fpu_op);
    assign {fpu_ovf3, fpu_sign3, fpu_exp3, fpu_mant3} = fp_model(fpu_a3, fpu_b3, fpu_op3);

    fp_add_arbiter #(.ADD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_sign(fpu_sign), .fpu_exp(fpu_exp),
        .fpu_mant(fpu_mant), .fpu_ovf(fpu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .busy(busy), .op_count(op_count)
    );

    fp_add_arbiter #(.ADD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid3), .req0_ready(req0_ready3), .req0_a(req0_a3),
        .req0_b(req0_b3), .req0_op(req0_op3),
        .req1_valid(req1_valid3), .req1_ready(req1_ready3), .req1_a(req1_a3),
        .req1_b(req1_b3), .req1_op(req1_op3),
        .fpu_a(fpu_a3), .fpu_b(fpu_b3), .fpu_op(fpu_op3), .fpu_sign(fpu_sign3),
        .fpu_exp(fpu_exp3), .fpu_mant(fpu_mant3), .fpu_ovf(fpu_ovf3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
        .rsp_result(rsp_result3), .rsp_ovf(rsp_ovf3), .busy(busy3), .op_count(op_count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench on the negedge where rsp_valid was first seen high.
    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
    endtask

    initial begin
        int ng;
        int nr;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rsp_ready = 0;
        req0_valid3 = 0; req0_a3 = 0; req0_b3 = 0; req0_op3 = 0;
        req1_valid3 = 0; req1_a3 = 0; req1_b3 = 0; req1_op3 = 0;
        rsp_ready3 = 0;

        @(negedge clk);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", op_count, 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_result", rsp_result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1.0 + 1.0 with ADD_LAT=1
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 16'h3C00; req0_b = 16'h3C00; req0_op = 1; rsp_ready = 1;
        @(negedge clk);
        chk("t1_ready0", req0_ready, 1);
        chk("t1_ready1", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 0;
        @(negedge clk);
        chk("t1_wait_valid", rsp_valid, 0);
        chk("t1_busy", busy, 1);
        chk("t1_fpu_a", fpu_a, 16'h3C00);
        @(negedge clk);
        chk("t1_valid", rsp_valid, 1);
        chk("t1_id", rsp_id, 0);
        chk("t1_result", rsp_result, 16'h4000);
        chk("t1_ovf", rsp_ovf, 0);
        @(negedge clk);
        chk("t1_count", op_count, 1);
        chk("t1_idle", busy, 0);

        // Both requesters held valid after a fresh reset
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req0_valid = 1; req0_a = 16'h4000; req0_b = 16'h3C00; req0_op = 1;
        req1_valid = 1; req1_a = 16'h4200; req1_b = 16'h3C00; req1_op = 0;
        rsp_ready = 1;
        ng = 0;
        nr = 0;
        for (int c = 0; c < 40 && nr < 4; c++) begin
            @(negedge clk);
            chk("t2_excl", req0_ready & req1_ready, 0);
            if (req0_ready || req1_ready) begin
                if (ng < 4) chk("t2_grant", req1_ready, ng % 2);
                ng++;
            end
            if (rsp_valid && rsp_ready) begin
                chk("t2_id", rsp_id, nr % 2);
                chk("t2_result", rsp_result, (nr % 2 == 1) ? 16'h4000 : 16'h4200);
                nr++;
            end
        end
        if (nr < 4) chk("t2_rsp_count", nr, 4);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 0;
        @(negedge clk);
        chk("t2_count", op_count, 4);
        chk("t2_idle", busy, 0);

        // Response back-pressure for 10 cycles
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 16'h3C00; req0_b = 16'h3C00; req0_op = 1; rsp_ready = 0;
        @(negedge clk);
        chk("t3_ready0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 1;
        wait_rsp();
        for (int i = 0; i < 10; i++) begin
            chk("t3_valid", rsp_valid, 1);
            chk("t3_id", rsp_id, 0);
            chk("t3_result", rsp_result, 16'h4000);
            chk("t3_busy", busy, 1);
            chk("t3_ready", {req0_ready, req1_ready}, 0);
            chk("t3_count", op_count, 4);
            @(negedge clk);
        end
        rsp_ready = 1;
        req1_valid = 0;
        @(negedge clk);
        chk("t3_count_after", op_count, 5);
        chk("t3_valid_after", rsp_valid, 0);

        // Asynchronous reset while an operation is in WAIT
        @(posedge clk); #1;
        req1_valid = 1; req1_a = 16'h1234; req1_b = 16'h0001; req1_op = 0;
        @(negedge clk);
        chk("t4_ready1", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_valid", rsp_valid, 0);
        chk("t4_busy", busy, 0);
        chk("t4_fpu_a", fpu_a, 0);
        chk("t4_count", op_count, 0);
        chk("t4_result", rsp_result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_no_answer", rsp_valid, 0);
        end
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 16'h3C00; req0_b = 16'h3C00; req0_op = 1;
        req1_valid = 1;
        @(negedge clk);
        chk("t4_first_grant", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 0;
        wait_rsp();
        chk("t4_id", rsp_id, 0);
        chk("t4_res", rsp_result, 16'h4000);
        @(negedge clk);
        chk("t4_count_after", op_count, 1);

        // ADD_LAT=3, single requester 1 op; operand change during WAIT is ignored
        @(posedge clk); #1;
        req1_valid3 = 1; req1_a3 = 16'h4000; req1_b3 = 16'h3C00; req1_op3 = 1; rsp_ready3 = 1;
        @(negedge clk);
        chk("t5_ready1", req1_ready3, 1);
        @(posedge clk); #1;
        req1_valid3 = 0;
        req1_a3 = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_fpu_a", fpu_a3, 16'h4000);
            chk("t5_fpu_b", fpu_b3, 16'h3C00);
            chk("t5_fpu_op", fpu_op3, 1);
            chk("t5_early", rsp_valid3, 0);
        end
        @(negedge clk);
        chk("t5_valid", rsp_valid3, 1);
        chk("t5_id", rsp_id3, 1);
        chk("t5_result", rsp_result3, 16'h4200);

        // Overflowing add: flag and result pass straight through
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 16'h7BFF; req0_b = 16'h7BFF; req0_op = 1;
        @(negedge clk);
        chk("t6_ready0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        wait_rsp();
        chk("t6_ovf", rsp_ovf, 1);
        chk("t6_result", rsp_result, 16'h7C00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
